// File: rtl/core_mem_pkg.sv
// Shared types and helpers for the core memory bus arbiter.
// Provides ID sizing, byte-enable sizing and the round-robin pick function.
package core_mem_pkg;

    // Upper bound on ports the round-robin helper can scan.
    localparam int unsigned MAX_PORTS = 32;

    // Width of a port ID; a single port still needs one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? unsigned'($clog2(n)) : 1;
    endfunction

    function automatic int unsigned be_width(input int unsigned dw);
        return dw / 8;
    endfunction

    // First requesting port strictly after 'last', wrapping at n.
    // The port at 'last' itself is checked last.
    // Returns 'last' when nothing requests.
    function automatic int unsigned rr_next(
        input logic [MAX_PORTS-1:0] req,
        input int unsigned          last,
        input int unsigned          n
    );
        int unsigned idx;
        int unsigned res;
        logic        found;
        res   = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_PORTS; k++) begin
            idx = last + k;
            if (idx >= n) idx = idx - n;
            if (!found && k <= n) begin
                if (req[idx[4:0]]) begin
                    res   = idx;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/core_mem_id_fifo.sv
// Synchronous FIFO holding the port IDs of granted, unanswered requests.
// Ports: clk_i, rst_i, push_i/data_i, pop_i, head_o, count_o, full_o, empty_o.
module core_mem_id_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 1,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        full_o  = (cnt_q == CNT_W'(DEPTH));
        empty_o = (cnt_q == '0);
        head_o  = mem_q[rd_q];
        count_o = cnt_q;
        do_push = push_i & ~full_o;
        do_pop  = pop_i & ~empty_o;
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = data_i;
            wr_d        = wrap_inc(wr_q);
        end
        if (do_pop) begin
            rd_d = wrap_inc(rd_q);
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read when count is nonzero.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/core_memory_arbiter.sv
// N-port to 1-port req/gnt/rvalid arbiter with round-robin, locking and in-order responses.
// Ports: slv_* per-port request/response, mem_* shared memory side, outstanding_o count, err_o sticky.
module core_memory_arbiter
    import core_mem_pkg::*;
#(
    parameter  int unsigned N_PORTS         = 2,
    parameter  int unsigned ADDR_WIDTH      = 32,
    parameter  int unsigned DATA_WIDTH      = 32,
    parameter  int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned BE_WIDTH        = be_width(DATA_WIDTH),
    localparam int unsigned ID_W            = id_width(N_PORTS),
    localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [N_PORTS-1:0]                   slv_req_i,
    output logic [N_PORTS-1:0]                   slv_gnt_o,
    input  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]   slv_addr_i,
    input  logic [N_PORTS-1:0]                   slv_we_i,
    input  logic [N_PORTS-1:0][BE_WIDTH-1:0]     slv_be_i,
    input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]   slv_wdata_i,
    output logic [N_PORTS-1:0]                   slv_rvalid_o,
    output logic [N_PORTS-1:0][DATA_WIDTH-1:0]   slv_rdata_o,
    output logic                                 mem_req_o,
    input  logic                                 mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]                mem_addr_o,
    output logic                                 mem_we_o,
    output logic [BE_WIDTH-1:0]                  mem_be_o,
    output logic [DATA_WIDTH-1:0]                mem_wdata_o,
    input  logic                                 mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                mem_rdata_i,
    output logic [CNT_W-1:0]                     outstanding_o,
    output logic                                 err_o
);

    logic [ID_W-1:0] rr_q, rr_d;
    logic [ID_W-1:0] lock_sel_q, lock_sel_d;
    logic            lock_q, lock_d;
    logic            err_q, err_d;
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] sel;
    logic [ID_W-1:0] head;
    logic            hs;
    logic            pop;
    logic            full;
    logic            empty;

    core_mem_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ID_W)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (hs),
        .data_i  (sel),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (outstanding_o),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        pick = ID_W'(rr_next(MAX_PORTS'(slv_req_i), 32'(rr_q), N_PORTS));
        // A stalled request keeps its port so the memory side sees stable fields.
        sel  = lock_q ? lock_sel_q : pick;

        // No push while full, even if a response frees a slot this cycle.
        mem_req_o   = ~full & slv_req_i[sel];
        mem_addr_o  = slv_addr_i[sel];
        mem_we_o    = slv_we_i[sel];
        mem_be_o    = slv_be_i[sel];
        mem_wdata_o = slv_wdata_i[sel];

        hs        = mem_req_o & mem_gnt_i;
        slv_gnt_o = '0;
        if (hs) slv_gnt_o[sel] = 1'b1;

        // Stalled request locks; handshake or a dropped request unlocks.
        lock_d     = mem_req_o & ~mem_gnt_i;
        lock_sel_d = sel;
        rr_d       = hs ? sel : rr_q;

        pop          = mem_rvalid_i & ~empty;
        slv_rvalid_o = '0;
        if (pop) slv_rvalid_o[head] = 1'b1;
        for (int i = 0; i < int'(N_PORTS); i++) begin
            slv_rdata_o[i] = mem_rdata_i;
        end

        err_d = err_q | (mem_rvalid_i & empty);
        err_o = err_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= ID_W'(N_PORTS - 1);
            lock_q     <= 1'b0;
            lock_sel_q <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_core_memory_arbiter.sv
// Self-checking bench for core_memory_arbiter: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_core_memory_arbiter;

    localparam int NP = 2;
    localparam int MO = 4;

    logic             clk;
    logic             rst;
    logic [1:0]       req;
    logic [1:0]       gnt_o;
    logic [1:0][31:0] addr;
    logic [1:0]       we;
    logic [1:0][3:0]  be;
    logic [1:0][31:0] wd;
    logic [1:0]       rv_o;
    logic [1:0][31:0] rdata_o;
    logic             mreq;
    logic             gnt;
    logic [31:0]      maddr;
    logic             mwe;
    logic [3:0]       mbe;
    logic [31:0]      mwd;
    logic             rv;
    logic [31:0]      mrdata;
    logic [2:0]       outst;
    logic             err;

    int errors = 0;
    int checks = 0;

    int rr_m;
    int lock_m;
    int mq[$];
    bit err_m;

    core_memory_arbiter #(
        .N_PORTS         (NP),
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .slv_req_i     (req),
        .slv_gnt_o     (gnt_o),
        .slv_addr_i    (addr),
        .slv_we_i      (we),
        .slv_be_i      (be),
        .slv_wdata_i   (wd),
        .slv_rvalid_o  (rv_o),
        .slv_rdata_o   (rdata_o),
        .mem_req_o     (mreq),
        .mem_gnt_i     (gnt),
        .mem_addr_o    (maddr),
        .mem_we_o      (mwe),
        .mem_be_o      (mbe),
        .mem_wdata_o   (mwd),
        .mem_rvalid_i  (rv),
        .mem_rdata_i   (mrdata),
        .outstanding_o (outst),
        .err_o         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [1:0] r, input logic g, input logic v);
        req = r;
        gnt = g;
        rv  = v;
        #1;
    endtask

    task automatic do_reset();
        req = '0;
        gnt = 1'b0;
        rv  = 1'b0;
        rst = 1'b1;
        nxt();
        rst    = 1'b0;
        rr_m   = NP - 1;
        lock_m = -1;
        mq.delete();
        err_m  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drv(2'b00, 1'b0, 1'b0);
        checks++; if (mreq !== 1'b0) begin errors++; $display("FAIL reset_mreq got %b want 0", mreq); end
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b want 00", gnt_o); end
        checks++; if (rv_o !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b want 00", rv_o); end
        checks++; if (outst !== 3'd0) begin errors++; $display("FAIL reset_outst got %0d want 0", outst); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    endtask

    task automatic test_alternate();
        logic [1:0] eg;
        logic [1:0] erv;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drv(2'b11, 1'b1, k > 0);
            eg  = (k % 2 == 0) ? 2'b01 : 2'b10;
            erv = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
            checks++; if (gnt_o !== eg) begin errors++; $display("FAIL alt_gnt[%0d] got %b want %b", k, gnt_o, eg); end
            checks++; if (rv_o !== erv) begin errors++; $display("FAIL alt_rvalid[%0d] got %b want %b", k, rv_o, erv); end
            checks++; if (outst !== 3'((k == 0) ? 0 : 1)) begin errors++; $display("FAIL alt_outst[%0d] got %0d", k, outst); end
            nxt();
        end
        drv(2'b00, 1'b0, 1'b1);
        checks++; if (rv_o !== 2'b10) begin errors++; $display("FAIL alt_last_rvalid got %b want 10", rv_o); end
        nxt();
        drv(2'b00, 1'b0, 1'b0);
        checks++; if (outst !== 3'd0) begin errors++; $display("FAIL alt_drain got %0d want 0", outst); end
    endtask

    task automatic test_lock();
        logic [31:0] a0;
        logic [31:0] a1;
        do_reset();
        a0 = 32'h0000_1000;
        a1 = 32'h0000_2000;
        addr[0] = a0;
        addr[1] = a1;
        for (int c = 0; c < 4; c++) begin
            drv((c == 0) ? 2'b10 : 2'b11, c == 3, 1'b0);
            checks++; if (maddr !== a1) begin errors++; $display("FAIL lock_addr[%0d] got %h want %h", c, maddr, a1); end
            checks++; if (mreq !== 1'b1) begin errors++; $display("FAIL lock_mreq[%0d] got %b want 1", c, mreq); end
            checks++; if (gnt_o !== ((c == 3) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL lock_gnt[%0d] got %b", c, gnt_o); end
            nxt();
        end
        drv(2'b01, 1'b1, 1'b0);
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL lock_gnt_p0 got %b want 01", gnt_o); end
        checks++; if (maddr !== a0) begin errors++; $display("FAIL lock_addr_p0 got %h want %h", maddr, a0); end
        nxt();
        drv(2'b00, 1'b0, 1'b1);
        checks++; if (rv_o !== 2'b10) begin errors++; $display("FAIL lock_rv1 got %b want 10", rv_o); end
        nxt();
        drv(2'b00, 1'b0, 1'b1);
        checks++; if (rv_o !== 2'b01) begin errors++; $display("FAIL lock_rv2 got %b want 01", rv_o); end
        nxt();
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drv(2'b01, 1'b1, 1'b0);
            checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL bp_gnt[%0d] got %b want 01", c, gnt_o); end
            checks++; if (outst !== 3'(c)) begin errors++; $display("FAIL bp_outst[%0d] got %0d want %0d", c, outst, c); end
            nxt();
        end
        drv(2'b01, 1'b1, 1'b1);
        checks++; if (mreq !== 1'b0) begin errors++; $display("FAIL bp_full_mreq got %b want 0", mreq); end
        checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL bp_full_gnt got %b want 00", gnt_o); end
        checks++; if (outst !== 3'd4) begin errors++; $display("FAIL bp_full_outst got %0d want 4", outst); end
        checks++; if (rv_o !== 2'b01) begin errors++; $display("FAIL bp_full_rv got %b want 01", rv_o); end
        nxt();
        drv(2'b01, 1'b1, 1'b0);
        checks++; if (outst !== 3'd3) begin errors++; $display("FAIL bp_after_outst got %0d want 3", outst); end
        checks++; if (mreq !== 1'b1) begin errors++; $display("FAIL bp_after_mreq got %b want 1", mreq); end
        nxt();
    endtask

    task automatic test_push_pop();
        do_reset();
        drv(2'b11, 1'b1, 1'b0);
        nxt();
        drv(2'b11, 1'b1, 1'b0);
        nxt();
        drv(2'b11, 1'b1, 1'b1);
        checks++; if (outst !== 3'd2) begin errors++; $display("FAIL pp_before got %0d want 2", outst); end
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL pp_gnt got %b want 01", gnt_o); end
        checks++; if (rv_o !== 2'b01) begin errors++; $display("FAIL pp_rv got %b want 01", rv_o); end
        nxt();
        drv(2'b00, 1'b0, 1'b1);
        checks++; if (outst !== 3'd2) begin errors++; $display("FAIL pp_after got %0d want 2", outst); end
        checks++; if (rv_o !== 2'b10) begin errors++; $display("FAIL pp_rv2 got %b want 10", rv_o); end
        nxt();
        drv(2'b00, 1'b0, 1'b1);
        checks++; if (rv_o !== 2'b01) begin errors++; $display("FAIL pp_rv3 got %b want 01", rv_o); end
        nxt();
        drv(2'b00, 1'b0, 1'b0);
        checks++; if (outst !== 3'd0) begin errors++; $display("FAIL pp_drain got %0d want 0", outst); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL pp_err got %b want 0", err); end
    endtask

    task automatic test_err();
        do_reset();
        drv(2'b00, 1'b0, 1'b1);
        checks++; if (rv_o !== 2'b00) begin errors++; $display("FAIL err_rv got %b want 00", rv_o); end
        nxt();
        drv(2'b00, 1'b0, 1'b0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", err); end
        checks++; if (outst !== 3'd0) begin errors++; $display("FAIL err_outst got %0d want 0", outst); end
        nxt();
        nxt();
        nxt();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
        do_reset();
        drv(2'b00, 1'b0, 1'b0);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        addr[0] = 32'hAAAA_0000;
        addr[1] = 32'hBBBB_0000;
        for (int c = 0; c < 3; c++) begin
            drv(2'b11, 1'b1, 1'b0);
            nxt();
        end
        drv(2'b00, 1'b0, 1'b0);
        checks++; if (outst !== 3'd3) begin errors++; $display("FAIL mid_pre got %0d want 3", outst); end
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        drv(2'b00, 1'b0, 1'b0);
        checks++; if (outst !== 3'd0) begin errors++; $display("FAIL mid_flush got %0d want 0", outst); end
        drv(2'b11, 1'b0, 1'b0);
        checks++; if (maddr !== 32'hAAAA_0000) begin errors++; $display("FAIL mid_rr got %h want aaaa0000", maddr); end
        nxt();
        drv(2'b00, 1'b0, 1'b1);
        checks++; if (mreq !== 1'b0) begin errors++; $display("FAIL drop_mreq got %b want 0", mreq); end
        checks++; if (rv_o !== 2'b00) begin errors++; $display("FAIL stale_rv got %b want 00", rv_o); end
        nxt();
        drv(2'b10, 1'b1, 1'b0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL stale_err got %b want 1", err); end
        checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL drop_unlock got %b want 10", gnt_o); end
        nxt();
    endtask

    task automatic test_random(input int n);
        int         sel;
        int         j;
        bit         full;
        bit         e_req;
        logic [1:0] e_gnt;
        logic [1:0] e_rv;
        do_reset();
        for (int c = 0; c < n; c++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            req = 2'($urandom_range(0, 3));
            gnt = ($urandom_range(0, 3) != 0);
            rv  = (mq.size() > 0) && ($urandom_range(0, 2) == 0);
            mrdata = $urandom;
            for (int p = 0; p < NP; p++) begin
                addr[p] = $urandom;
                we[p]   = 1'($urandom);
                be[p]   = 4'($urandom);
                wd[p]   = $urandom;
            end
            full = (mq.size() == MO);
            sel  = lock_m;
            if (sel < 0) begin
                for (int i = 1; i <= NP; i++) begin
                    j = (rr_m + i) % NP;
                    if (sel < 0 && req[j]) sel = j;
                end
            end
            e_req = !full && (sel >= 0) && req[sel];
            e_gnt = (e_req && gnt) ? 2'(1 << sel) : 2'b00;
            e_rv  = (rv && mq.size() > 0) ? 2'(1 << mq[0]) : 2'b00;
            #1;
            checks++; if (outst !== 3'(mq.size())) begin errors++; $display("FAIL rnd_outst[%0d] got %0d want %0d", c, outst, mq.size()); end
            checks++; if (err !== err_m) begin errors++; $display("FAIL rnd_err[%0d] got %b want %b", c, err, err_m); end
            checks++; if (mreq !== e_req) begin errors++; $display("FAIL rnd_mreq[%0d] got %b want %b", c, mreq, e_req); end
            checks++; if (gnt_o !== e_gnt) begin errors++; $display("FAIL rnd_gnt[%0d] got %b want %b", c, gnt_o, e_gnt); end
            checks++; if (rv_o !== e_rv) begin errors++; $display("FAIL rnd_rv[%0d] got %b want %b", c, rv_o, e_rv); end
            if (e_req) begin
                checks++;
                if ({maddr, mwe, mbe, mwd} !== {addr[sel], we[sel], be[sel], wd[sel]}) begin
                    errors++;
                    $display("FAIL rnd_fields[%0d] got %h/%b/%h/%h want %h/%b/%h/%h", c,
                             maddr, mwe, mbe, mwd, addr[sel], we[sel], be[sel], wd[sel]);
                end
            end
            if (rv) begin
                checks++;
                if (rdata_o[0] !== mrdata || rdata_o[1] !== mrdata) begin
                    errors++;
                    $display("FAIL rnd_rdata[%0d] got %h/%h want %h", c, rdata_o[0], rdata_o[1], mrdata);
                end
            end
            if (rv) begin
                if (mq.size() > 0) void'(mq.pop_front());
                else err_m = 1'b1;
            end
            if (e_req && gnt) begin
                mq.push_back(sel);
                rr_m   = sel;
                lock_m = -1;
            end else if (e_req) begin
                lock_m = sel;
            end else begin
                lock_m = -1;
            end
            nxt();
        end
    endtask

    initial begin
        rst    = 1'b1;
        req    = '0;
        gnt    = 1'b0;
        rv     = 1'b0;
        addr   = '0;
        we     = '0;
        be     = '0;
        wd     = '0;
        mrdata = 32'h1234_5678;
        nxt();
        test_reset();
        test_alternate();
        test_lock();
        test_backpressure();
        test_push_pop();
        test_err();
        test_reset_mid();
        test_random(400);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
